// File: rtl/dtree_feature_streamer.sv
// Streams feature bytes into a vector, captures the tree class and holds it.
// Optional checksum byte after each vector: define FEATURE_CHECKSUM_EN.
module dtree_feature_streamer #(
    parameter int NUM_FEAT = 18,
    parameter int FEAT_W   = 8,
    parameter int CLS_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    input  logic [FEAT_W-1:0]          s_data,
    output logic                       s_ready,
    output logic [NUM_FEAT*FEAT_W-1:0] feat_bus,
    input  logic [CLS_W-1:0]           cls_in,
    output logic                       m_valid,
    output logic [CLS_W-1:0]           m_class,
    output logic                       m_err,
    input  logic                       m_ready,
    output logic                       busy
);

    localparam int CNT_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_FEAT - 1);

    localparam logic [1:0] S_LOAD = 2'd0;
`ifdef FEATURE_CHECKSUM_EN
    localparam logic [1:0] S_CHK  = 2'd1;
`endif
    localparam logic [1:0] S_EVAL = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]                 r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic [NUM_FEAT*FEAT_W-1:0] r_feat;
    logic                       r_m_valid;
    logic [CLS_W-1:0]           r_m_class;

    logic w_accept;
    logic w_last;
    logic w_release;

`ifdef FEATURE_CHECKSUM_EN
    assign s_ready = (r_state == S_LOAD) || (r_state == S_CHK);
`else
    assign s_ready = (r_state == S_LOAD);
`endif

    assign w_accept  = s_valid && s_ready;
    assign w_last    = (r_cnt == LAST);
    assign w_release = (r_state == S_HOLD) && r_m_valid && m_ready;

    assign feat_bus = r_feat;
    assign m_valid  = r_m_valid;
    assign m_class  = r_m_class;
    assign busy     = (r_state != S_LOAD) || (r_cnt != '0);

    // Sequencing: byte slot counter and state transitions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_cnt <= '0;
`ifdef FEATURE_CHECKSUM_EN
                            r_state <= S_CHK;
`else
                            r_state <= S_EVAL;
`endif
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
`ifdef FEATURE_CHECKSUM_EN
                S_CHK: begin
                    if (w_accept) begin
                        r_state <= S_EVAL;
                    end
                end
`endif
                S_EVAL: begin
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (w_release) begin
                        r_state <= S_LOAD;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Feature slots: only an accepted feature byte writes its own slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_feat <= '0;
        end else if ((r_state == S_LOAD) && w_accept) begin
            for (int k = 0; k < NUM_FEAT; k++) begin
                if (r_cnt == CNT_W'(k)) begin
                    r_feat[k*FEAT_W +: FEAT_W] <= s_data;
                end
            end
        end
    end

    // Result capture on leaving EVAL, released by the downstream handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_class <= '0;
        end else if (r_state == S_EVAL) begin
            r_m_valid <= 1'b1;
            r_m_class <= cls_in;
        end else if (w_release) begin
            r_m_valid <= 1'b0;
        end
    end

`ifdef FEATURE_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       r_chk_err;
    logic       r_m_err;

    assign m_err = r_m_err;

    // Running mod-256 sum of features and compare against the trailing byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum     <= '0;
            r_chk_err <= 1'b0;
        end else if ((r_state == S_LOAD) && w_accept) begin
            r_sum <= r_sum + 8'(s_data);
        end else if ((r_state == S_CHK) && w_accept) begin
            r_chk_err <= (8'(s_data) != r_sum);
        end else if (w_release) begin
            r_sum <= '0;
        end
    end

    // Error flag is captured alongside the class
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_err <= 1'b0;
        end else if (r_state == S_EVAL) begin
            r_m_err <= r_chk_err;
        end
    end
`else
    assign m_err = 1'b0;
`endif

endmodule

// File: tb/tb_dtree_feature_streamer.sv
// Testbench for dtree_feature_streamer: table vectors, corner sequences,
// and randomized vectors against a sum-based classifier stand-in.
module tb_dtree_feature_streamer;

    localparam int NF = 18;
    localparam int FW = 8;
    localparam int CW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_valid = 1'b0;
    logic [FW-1:0]    s_data = '0;
    logic             s_ready;
    logic [NF*FW-1:0] feat_bus;
    logic [CW-1:0]    cls_in;
    logic             m_valid;
    logic [CW-1:0]    m_class;
    logic             m_err;
    logic             m_ready = 1'b0;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dtree_feature_streamer #(
        .NUM_FEAT(NF),
        .FEAT_W  (FW),
        .CLS_W   (CW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .feat_bus(feat_bus),
        .cls_in  (cls_in),
        .m_valid (m_valid),
        .m_class (m_class),
        .m_err   (m_err),
        .m_ready (m_ready),
        .busy    (busy)
    );

    // Classifier stand-in: class = sum of all features mod 4
    always_comb begin : cls_model
        int s;
        s = 0;
        for (int k = 0; k < NF; k++) s += int'(feat_bus[k*FW +: FW]);
        cls_in = CW'(s);
    end

    typedef struct {
        logic [7:0] base;
        logic [7:0] step;
        logic [1:0] exp_cls;
        logic [7:0] exp_f0;
        logic [7:0] exp_f17;
    } vec_t;

    logic [7:0] vb [NF];

    task automatic chk(input string name, input logic [NF*FW-1:0] act,
                       input logic [NF*FW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int t;
        s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = b;
        t = 0;
        while (!s_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!s_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got s_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    // Sends vb[] (plus checksum when enabled) and checks the whole result
    task automatic run_vec(input int gap_mode, input int hold,
                           input logic [7:0] chk_off,
                           input logic [1:0] exp_cls);
        int              sum;
        int              gap;
        logic            exp_err;
        logic [NF*FW-1:0] exp_bus;
        sum = 0;
        exp_bus = '0;
        for (int k = 0; k < NF; k++) begin
            gap = (gap_mode == 0) ? 0 :
                  (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
            send(vb[k], gap);
            sum += int'(vb[k]);
            exp_bus[k*FW +: FW] = vb[k];
        end
`ifdef FEATURE_CHECKSUM_EN
        send(8'(sum) + chk_off, 0);
        exp_err = (chk_off != 8'd0);
`else
        exp_err = 1'b0;
`endif
        chk("eval_m_valid_low", m_valid, 0);
        chk("eval_busy", busy, 1);
        chk("eval_s_ready_low", s_ready, 0);
        @(posedge clk);
        #1;
        chk("m_valid_latency", m_valid, 1);
        chk("m_class", m_class, exp_cls);
        chk("m_err", m_err, exp_err);
        chk("feat_bus", feat_bus, exp_bus);
        s_valid = 1'b1;
        s_data  = 8'h55;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_m_valid", m_valid, 1);
            chk("hold_m_class", m_class, exp_cls);
            chk("hold_s_ready", s_ready, 0);
            chk("hold_feat_bus", feat_bus, exp_bus);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        chk("release_m_valid", m_valid, 0);
        chk("release_s_ready", s_ready, 1);
        chk("release_busy", busy, 0);
        chk("release_feat_bus", feat_bus, exp_bus);
    endtask

    initial begin
        vec_t tbl [5];
        int   sum;

        tbl[0] = '{8'd1,   8'd1, 2'd3, 8'h01, 8'h12};
        tbl[1] = '{8'hAA,  8'd0, 2'd0, 8'hAA, 8'hAA};
        tbl[2] = '{8'h00,  8'd0, 2'd0, 8'h00, 8'h00};
        tbl[3] = '{8'hFF,  8'd0, 2'd2, 8'hFF, 8'hFF};
        tbl[4] = '{8'd2,   8'd3, 2'd3, 8'h02, 8'h35};

        #12;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_class", m_class, 0);
        chk("rst_m_err", m_err, 0);
        chk("rst_feat_bus", feat_bus, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_s_ready", s_ready, 1);

        // Table vectors, back-to-back bytes
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < NF; k++) vb[k] = tbl[v].base + 8'(k) * tbl[v].step;
            run_vec(0, 0, 8'd0, tbl[v].exp_cls);
            chk("tbl_f0", feat_bus[7:0], tbl[v].exp_f0);
            chk("tbl_f17", feat_bus[143:136], tbl[v].exp_f17);
        end

        // Long hold with stray s_valid, then alternating s_valid
        for (int k = 0; k < NF; k++) vb[k] = 8'(k + 1);
        run_vec(0, 10, 8'd0, 2'd3);
        run_vec(1, 0, 8'd0, 2'd3);
        chk("alt_f0", feat_bus[7:0], 8'h01);
        chk("alt_f17", feat_bus[143:136], 8'h12);

        // Reset in the middle of a vector
        for (int k = 0; k < 7; k++) send(8'(8'h30 + k), 0);
        #2;
        rst_n = 1'b0;
        #2;
        chk("midrst_feat_bus", feat_bus, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_m_valid", m_valid, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_s_ready", s_ready, 1);
        for (int k = 0; k < NF; k++) vb[k] = 8'hAA;
        run_vec(0, 0, 8'd0, 2'd0);
        chk("midrst_f6", feat_bus[55:48], 8'hAA);

`ifdef FEATURE_CHECKSUM_EN
        for (int k = 0; k < NF; k++) vb[k] = 8'h10;
        run_vec(0, 0, 8'd0, 2'd0);
        run_vec(0, 2, 8'd1, 2'd0);
        run_vec(2, 0, 8'd0, 2'd0);
`endif

        // Back-to-back vectors
        for (int k = 0; k < NF; k++) vb[k] = 8'(8'h40 + k);
        run_vec(0, 0, 8'd0, 2'd1);
        for (int k = 0; k < NF; k++) vb[k] = 8'(8'hC0 - k);
        run_vec(0, 0, 8'd0, 2'd3);

        // Randomized vectors checked against the sum model
        for (int v = 0; v < 8; v++) begin
            sum = 0;
            for (int k = 0; k < NF; k++) begin
                vb[k] = 8'($urandom);
                sum += int'(vb[k]);
            end
            run_vec(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                    8'($urandom_range(0, 1)), 2'(sum));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dtree_feature_streamer.md
DTREE_FEATURE_STREAMER -- requirements
Module: dtree_feature_streamer

Interface
REQ-001 Parameter NUM_FEAT, default 18: number of features per vector.
REQ-002 Parameter FEAT_W, default 8: feature width in bits.
REQ-003 Parameter CLS_W, default 2: class code width in bits.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 s_valid  input  1  inbound byte valid.
REQ-007 s_data  input  FEAT_W  inbound feature (or checksum) byte.
REQ-008 s_ready  output  1  streamer accepts s_data this cycle.
REQ-009 feat_bus  output  NUM_FEAT*FEAT_W  assembled vector to classifier; feature k at bits [k*FEAT_W +: FEAT_W].
REQ-010 cls_in  input  CLS_W  combinational class from attached tree classifier.
REQ-011 m_valid  output  1  result valid.
REQ-012 m_class  output  CLS_W  captured class.
REQ-013 m_err  output  1  checksum mismatch for this result.
REQ-014 m_ready  input  1  downstream accepts result.
REQ-015 busy  output  1  high whenever state is not LOAD or cnt != 0.

Function
REQ-016 FSM states: LOAD, CHK (only when the macro is defined), EVAL, HOLD.
REQ-017 Inbound byte accepted when s_valid and s_ready are both high; s_ready high only in LOAD and CHK.
REQ-018 LOAD: accepted byte written to feature slot cnt, then cnt increments; at cnt == NUM_FEAT-1 acceptance goes to CHK (macro defined) or EVAL (not defined).
REQ-019 Feature bytes arrive in order, feature 0 first; no skipping or reordering.
REQ-020 EVAL lasts exactly one cycle; on leaving EVAL, cls_in registers into m_class and m_valid sets; next state HOLD.
REQ-021 Latency: last byte accepted at edge N gives m_valid high after edge N+1 (no CHK) or one cycle after the checksum byte is accepted (CHK).
REQ-022 HOLD: m_valid, m_class, m_err stay stable until m_valid && m_ready; on that edge m_valid clears, cnt = 0, state = LOAD.
REQ-023 feat_bus changes only on accepted feature bytes; it stays stable through EVAL and HOLD.
REQ-024 s_valid while s_ready is low is ignored; no byte is lost or consumed.
REQ-025 m_ready while m_valid is low has no effect.
REQ-026 cnt is ceil(log2(NUM_FEAT)) bits wide and never exceeds NUM_FEAT-1.

Reset
REQ-027 rst_n low immediately forces: state LOAD, cnt 0, all feature slots 0, m_valid 0, m_class 0, m_err 0, running sum 0.
REQ-028 Reset in any state discards any partial vector or pending result; after release the first accepted byte is feature 0.
REQ-029 s_ready is high in the first cycle after reset release.

Configuration
REQ-030 With FEATURE_CHECKSUM_EN defined: an 8-bit running sum (mod 256) of the feature bytes is kept.
REQ-031 With FEATURE_CHECKSUM_EN defined: CHK accepts one extra byte, and m_err = (byte != sum), captured with m_class.
REQ-032 With FEATURE_CHECKSUM_EN defined: the sum clears on entry to LOAD.
REQ-033 Without FEATURE_CHECKSUM_EN: CHK does not exist, no sum logic exists, and m_err is tied to 0.

Verification
REQ-034 Stream bytes 1..18 back-to-back, classifier model returns 2'd3, m_ready=1 -> m_valid one cycle after EVAL, m_class=3, m_err=0, feat_bus[7:0]=1, feat_bus[143:136]=18.
REQ-035 Hold m_ready=0 for 10 cycles after m_valid -> m_class stable, s_ready=0, extra s_valid bytes not consumed; raise m_ready -> s_ready=1 on the next cycle.
REQ-036 Toggle s_valid every other cycle across 18 bytes -> identical feat_bus and result as REQ-034.
REQ-037 Assert rst_n low after 7 bytes, release, then send 18 bytes of 0xAA -> all slots 0xAA, no residue from the first 7 bytes.
REQ-038 With FEATURE_CHECKSUM_EN: 18 bytes of 0x10 plus checksum 0x20 -> m_err=0; same bytes plus checksum 0x21 -> m_err=1.
REQ-039 Two vectors back-to-back with m_ready=1 -> two results in order, cnt restarts at 0 for the second vector.
